// File: rtl/stat_graph_render.sv
// rtl/stat_graph_render.sv - multi-channel event history line graph with per-channel auto-scale
// Optional STAT_GRAPH_FILL_EN draws a dimmed area fill beneath each channel's trace.
module stat_graph_render #(
  parameter int          NUM_CH        = 2,
  parameter int          HISTORY_LEN   = 32,
  parameter int          CNT_W         = 16,
  parameter int          SAMPLE_FRAMES = 32,
  parameter int          SCREEN_W      = 640,
  parameter int          SCREEN_H      = 480,
  parameter int          ORIGIN_X      = 400,
  parameter int          ORIGIN_Y      = 40,
  parameter int          GRAPH_W       = 256,
  parameter int          GRAPH_H       = 128,
  parameter logic [11:0] AXIS_COLOR    = 12'hFFF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic [NUM_CH-1:0]     inc_in,
  input  logic [12*NUM_CH-1:0]  ch_color_in,
  input  logic                  freeze_in,
  output logic [11:0]           pix_out,
  output logic                  sample_valid_out,
  output logic [5*NUM_CH-1:0]   shift_out
);
  localparam int PTR_W   = $clog2(HISTORY_LEN);
  localparam int SLOT_SH = $clog2(GRAPH_W / HISTORY_LEN);
  localparam int FC_W    = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;
  localparam int WORD_W  = NUM_CH * CNT_W;
  localparam int DW      = CNT_W + 10;

  localparam logic [10:0]      H_LAST   = 11'(SCREEN_W - 1);
  localparam logic [10:0]      H_SCR    = 11'(SCREEN_W);
  localparam logic [9:0]       V_LAST   = 10'(SCREEN_H - 1);
  localparam logic [9:0]       V_SCR    = 10'(SCREEN_H);
  localparam logic [10:0]      X0       = 11'(ORIGIN_X);
  localparam logic [10:0]      X_AX     = 11'(ORIGIN_X - 1);
  localparam logic [10:0]      X_END    = 11'(ORIGIN_X + GRAPH_W);
  localparam logic [9:0]       Y0       = 10'(ORIGIN_Y);
  localparam logic [9:0]       Y_BOT    = 10'(ORIGIN_Y + GRAPH_H - 1);
  localparam logic [9:0]       Y_AX     = 10'(ORIGIN_Y + GRAPH_H);
  localparam logic [CNT_W-1:0] SAT      = '1;
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(GRAPH_H - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SAMPLE_FRAMES - 1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(HISTORY_LEN);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} scan_state_t;

  scan_state_t        state, state_nxt;
  logic [FC_W-1:0]    frame_cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     fill;
  logic [CNT_W-1:0]   acc [NUM_CH];
  logic [CNT_W-1:0]   acc_nxt [NUM_CH];
  logic [WORD_W-1:0]  hist [HISTORY_LEN];
  logic [WORD_W-1:0]  wr_word, rd_word;
  logic [CNT_W-1:0]   rd_ch [NUM_CH];
  logic [PTR_W-1:0]   rd_addr;
  logic               acc_active, eof, commit;

  logic [PTR_W:0]     scan_idx;
  logic               scan_issue, scan_rd_v;
  logic [CNT_W-1:0]   max_val [NUM_CH];
  logic [5*NUM_CH-1:0] shift_calc, shift_pend;

  logic [10:0]        col;
  logic [PTR_W:0]     slot;
  logic [PTR_W-1:0]   entry;
  logic               s1_plot, s1_axis;
  logic [9:0]         s1_dist;
  logic [NUM_CH-1:0]  pt_hit;
  logic [11:0]        pix_nxt;

  assign eof        = (hcount_in == H_LAST) && (vcount_in == V_LAST);
  assign acc_active = (frame_cnt == '0) && (hcount_in < H_SCR) && (vcount_in < V_SCR);
  assign commit     = eof && (frame_cnt == '0) && !freeze_in;

  // The end-of-frame pixel's own strobe is folded in before the commit write.
  always_comb begin
    wr_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_nxt[c] = acc[c];
      if (acc_active && inc_in[c] && (acc[c] != SAT)) acc_nxt[c] = acc[c] + 1'b1;
      wr_word[c*CNT_W +: CNT_W] = acc_nxt[c];
      rd_ch[c] = rd_word[c*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      frame_cnt        <= '0;
      wr_ptr           <= '0;
      fill             <= '0;
      sample_valid_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      sample_valid_out <= commit;
      if (eof) begin
        frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
      end
      if (commit) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  // Scan owns the read port in vertical blank; rendering owns it in the active area.
  assign col     = hcount_in - X0;
  assign slot    = (PTR_W + 1)'(col >> SLOT_SH);
  assign entry   = wr_ptr - fill[PTR_W-1:0] + slot[PTR_W-1:0];
  assign rd_addr = (state == SCAN) ? scan_idx[PTR_W-1:0] : entry;

  always_ff @(posedge clk_in) begin
    if (commit) hist[wr_ptr] <= wr_word;
    rd_word <= hist[rd_addr];
  end

  assign scan_issue = (state == SCAN) && (scan_idx < fill);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hcount_in == 11'd0 && vcount_in == V_SCR) state_nxt = SCAN;
      SCAN:    if (scan_idx == fill && !scan_rd_v) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_calc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = CNT_W; s >= 0; s--) begin
        if ((max_val[c] >> s) <= H_MAX) shift_calc[5*c +: 5] = 5'(s);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      scan_idx   <= '0;
      scan_rd_v  <= 1'b0;
      shift_pend <= '0;
      shift_out  <= '0;
      for (int c = 0; c < NUM_CH; c++) max_val[c] <= '0;
    end else begin
      state     <= state_nxt;
      scan_rd_v <= scan_issue;
      if (state == IDLE && state_nxt == SCAN) begin
        scan_idx <= '0;
        for (int c = 0; c < NUM_CH; c++) max_val[c] <= '0;
      end else if (scan_issue) begin
        scan_idx <= scan_idx + 1'b1;
      end
      if (scan_rd_v) begin
        for (int c = 0; c < NUM_CH; c++)
          if (rd_ch[c] > max_val[c]) max_val[c] <= rd_ch[c];
      end
      if (state == APPLY) shift_pend <= shift_calc;
      if (hcount_in == 11'd0 && vcount_in == 10'd0) shift_out <= shift_pend;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_plot <= 1'b0;
      s1_axis <= 1'b0;
      s1_dist <= '0;
      pix_out <= '0;
    end else begin
      s1_plot <= (hcount_in >= X0) && (hcount_in < X_END) && (slot < fill) && (vcount_in <= Y_BOT);
      s1_dist <= Y_BOT - vcount_in;
      s1_axis <= ((vcount_in == Y_AX) && (hcount_in >= X_AX) && (hcount_in < X_END)) ||
                 ((hcount_in == X_AX) && (vcount_in >= Y0) && (vcount_in <= Y_AX));
      pix_out <= pix_nxt;
    end
  end

  // s1_dist is the height above the graph floor; a point sits where it equals the scaled sample.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      pt_hit[c] = s1_plot && (DW'(rd_ch[c] >> shift_out[5*c +: 5]) == DW'(s1_dist));
  end

`ifdef STAT_GRAPH_FILL_EN
  logic [NUM_CH-1:0] fill_hit;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      fill_hit[c] = s1_plot && (DW'(s1_dist) < DW'(rd_ch[c] >> shift_out[5*c +: 5]));
  end
`endif

  // Descending loops let the lowest channel index overwrite last and so win.
  always_comb begin
    pix_nxt = s1_axis ? AXIS_COLOR : 12'h000;
`ifdef STAT_GRAPH_FILL_EN
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (fill_hit[c])
        pix_nxt = {1'b0, ch_color_in[12*c+9 +: 3], 1'b0, ch_color_in[12*c+5 +: 3],
                   1'b0, ch_color_in[12*c+1 +: 3]};
    end
`endif
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pt_hit[c]) pix_nxt = ch_color_in[12*c +: 12];
    end
  end
endmodule

// File: tb/tb_stat_graph_render.sv
// tb/tb_stat_graph_render.sv - scoreboard bench for stat_graph_render
// CNT_W is reduced to 12 so counter saturation is reachable in a short run.
module tb_stat_graph_render;
  localparam int SAMPLE_FRAMES = 32;
  localparam int C0 = 12'hF00;
  localparam int C1 = 12'h0F0;
  localparam int AX = 12'hFFF;
`ifdef STAT_GRAPH_FILL_EN
  localparam int DIM0 = 12'h700;
`else
  localparam int DIM0 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [1:0]  inc = '0;
  logic [23:0] ch_color = {12'h0F0, 12'hF00};
  logic        freeze = 1'b0;
  logic [11:0] pix;
  logic        sv;
  logic [9:0]  shift;

  stat_graph_render #(.NUM_CH(2), .CNT_W(12), .SAMPLE_FRAMES(SAMPLE_FRAMES)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .inc_in(inc), .ch_color_in(ch_color), .freeze_in(freeze),
    .pix_out(pix), .sample_valid_out(sv), .shift_out(shift)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; int kind; int val; string name;} exp_t;
  exp_t q[$];
  int   vq[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: pops expectations as their due cycle arrives and tracks sample pulses.
  exp_t e;
  int   act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: check skipped (due %0d, now %0d)", e.name, e.due, cyc);
      end else begin
        act = (e.kind == 0) ? int'(pix) : int'(shift);
        if (act != e.val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
        end
      end
    end
    if (sv) begin
      checks++;
      if (vq.size() > 0 && vq[0] == cyc) void'(vq.pop_front());
      else begin
        errors++;
        $display("FAIL sample_valid: unexpected pulse at cycle %0d (got 1 expected 0)", cyc);
      end
    end
    while (vq.size() > 0 && vq[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL sample_valid: missing pulse at cycle %0d (got 0 expected 1)", vq[0]);
      void'(vq.pop_front());
    end
  end

  task automatic px(input int h, input int v, input logic [1:0] i = 2'b00, input logic f = 1'b0);
    hcount = 11'(h);
    vcount = 10'(v);
    inc    = i;
    freeze = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pix(input int h, input int v, input int ev, input string n);
    q.push_back('{cyc + 2, 0, ev, n});
    px(h, v);
  endtask

  task automatic chk_shift(input int s0, input int s1, input string n);
    q.push_back('{cyc + 1, 1, s1 * 32 + s0, n});
    px(0, 481);
  endtask

  task automatic vblank_scan();
    px(0, 480);
    repeat (40) px(0, 481);
    px(0, 0);
  endtask

  // One sample period; the last event of each channel lands on the end-of-frame pixel.
  task automatic sample(input int n0, input int n1, input logic f);
    for (int k = 1; k < ((n0 > n1) ? n0 : n1); k++) px(5, 5, {k < n1, k < n0});
    if (!f) vq.push_back(cyc + 1);
    px(639, 479, {n1 > 0, n0 > 0}, f);
    vblank_scan();
    repeat (SAMPLE_FRAMES - 1) px(639, 479);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (got timeout expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    rst_n = 1'b0;
    px(0, 481);
    px(0, 481);
    chk_shift(0, 0, "reset_shift");
    chk_pix(0, 481, 0, "reset_pix");
    px(0, 481);
    rst_n = 1'b1;

    chk_pix(399, 104, AX, "axis_col");
    chk_pix(410, 168, AX, "axis_row");
    chk_pix(399, 168, AX, "axis_corner");
    chk_pix(656, 168, 0, "axis_row_end");
    chk_pix(399, 39, 0, "axis_col_top");
    chk_pix(410, 167, 0, "empty_fill0");

    sample(100, 0, 1'b0);
    chk_shift(0, 0, "t1_shift");
    chk_pix(400, 67, C0, "t1_pt");
    chk_pix(407, 67, C0, "t1_pt_slot_edge");
    chk_pix(408, 67, 0, "t1_slot1_empty");
    chk_pix(400, 167, C1, "t1_ch1_pt");
    chk_pix(400, 100, DIM0, "t1_below_pt");

    sample(0, 1000, 1'b0);
    chk_shift(0, 3, "t2_shift");
    chk_pix(408, 42, C1, "t2_ch1_pt");
    chk_pix(408, 167, C0, "t2_ch0_zero");
    chk_pix(400, 67, C0, "t2_ch0_unchanged");
    chk_pix(400, 167, C1, "t2_slot0_ch1");

    sample(5000, 0, 1'b0);
    chk_shift(5, 3, "t3_sat_shift");
    chk_pix(416, 40, C0, "t3_sat_pt");
    chk_pix(400, 164, C0, "t3_rescaled");
    chk_pix(408, 42, C1, "t3_ch1_kept");

    repeat (6) px(5, 5, 2'b01);
    vq.push_back(cyc + 1);
    px(639, 479, 2'b01);
    px(0, 480);
    px(0, 481);
    px(0, 481);
    rst_n = 1'b0;
    px(0, 481);
    rst_n = 1'b1;
    chk_shift(0, 0, "rst_shift");
    chk_pix(400, 164, 0, "rst_empty_a");
    chk_pix(416, 40, 0, "rst_empty_b");
    chk_pix(399, 104, AX, "rst_axis");

    repeat (20) px(5, 5, 2'b10);
    rst_n = 1'b0;
    px(0, 481);
    rst_n = 1'b1;

    for (int i = 1; i <= 33; i++) begin
      sample(i, 0, 1'b0);
      if (i == 1) begin
        chk_shift(0, 0, "post_rst_shift");
        chk_pix(400, 167, C1, "post_rst_ch1");
        chk_pix(400, 166, C0, "post_rst_ch0");
      end
    end
    chk_shift(0, 0, "wrap_shift");
    chk_pix(400, 165, C0, "wrap_slot0");
    chk_pix(400, 166, DIM0, "wrap_slot0_old");
    chk_pix(655, 134, C0, "wrap_slot31");
    chk_pix(655, 167, C1, "wrap_slot31_ch1");

    sample(40, 0, 1'b1);
    chk_pix(400, 165, C0, "frz_slot0");
    chk_pix(655, 134, C0, "frz_slot31");

    sample(0, 0, 1'b0);
    chk_pix(655, 167, C0, "prio_slot31");
    chk_pix(647, 134, C0, "shift_slot30");
    chk_pix(400, 164, C0, "shift_slot0");

    repeat (5) px(0, 481);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
